// File: rtl/audio_sfx_mixer_pkg.sv
// Shared definitions for the audio SFX mixer: mix FSM state encoding,
// midscale helper and a constant-foldable ceil(log2) function.
package audio_pkg;

  // Mix sequencer states, one ADDR/WAIT/ACC triple per channel slot
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_OUT  = 3'd4
  } mix_state_e;

  // Ceiling log2, usable in parameter expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Unsigned sample midscale for a given sample width
  function automatic int midscale(input int sample_w);
    return 1 << (sample_w - 1);
  endfunction

  // Midscale of the default 8-bit sample path
  localparam int MIDSCALE_8B = 128;

endpackage

// File: rtl/audio_sfx_mixer_channel_ctrl.sv
// Per-channel playback control: active flag, sample offset counter,
// read-address generation and end-of-clip done pulse.
// Priority within a clock: stop, then trigger (non-zero length), then the
// channel's own ACC-slot advance.
module audio_channel_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              slot,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic              active,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done
);

  logic              active_q;
  logic              active_d;
  logic [ADDR_W-1:0] offset_q;
  logic [ADDR_W-1:0] offset_d;
  logic              done_s;
  logic              last_s;

  // Next-state for active/offset and the in-slot done pulse
  always_comb begin
    active_d = active_q;
    offset_d = offset_q;
    done_s   = 1'b0;
    last_s   = (offset_q == (len - {{(ADDR_W-1){1'b0}}, 1'b1}));
    if (stop) begin
      active_d = 1'b0;
    end else if (trigger && (len != {ADDR_W{1'b0}})) begin
      active_d = 1'b1;
      offset_d = {ADDR_W{1'b0}};
    end else if (slot && active_q) begin
      if (last_s) begin
        offset_d = {ADDR_W{1'b0}};
        if (loop_en) begin
          active_d = 1'b1;
        end else begin
          active_d = 1'b0;
          done_s   = 1'b1;
        end
      end else begin
        offset_d = offset_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      active_d = active_q;
      offset_d = offset_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      offset_q <= {ADDR_W{1'b0}};
    end else begin
      active_q <= active_d;
      offset_q <= offset_d;
    end
  end

  assign active  = active_q;
  assign rd_addr = base + offset_q;
  assign done    = done_s;

endmodule

// File: rtl/audio_sfx_mixer.sv
// Multi-channel sound-effect mixer. On each sample tick the sequencer walks
// every channel slot (ADDR, WAIT, ACC), sums signed contributions around
// midscale, then saturates and registers the mixed sample in OUT.
// Optional build macro: AUDIO_DUCK_EN halves channel 0 (music bed) whenever
// any other channel is playing.
module audio_sfx_mixer
  import audio_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_CH-1:0]        trigger,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        loop_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [SAMPLE_W-1:0]      mem_dout,
  output logic [SAMPLE_W-1:0]      audio_out,
  output logic                     sample_valid,
  output logic [NUM_CH-1:0]        active,
  output logic [NUM_CH-1:0]        done,
  output logic                     overrun
);

  localparam int K_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int ACC_W = SAMPLE_W + clog2(NUM_CH) + 1;
  localparam logic signed [ACC_W-1:0] MID_ACC = ACC_W'(midscale(SAMPLE_W));
  localparam logic signed [ACC_W-1:0] MAX_ACC = ACC_W'((1 << SAMPLE_W) - 1);
  localparam logic [SAMPLE_W-1:0]     MID_OUT = SAMPLE_W'(midscale(SAMPLE_W));

  mix_state_e              state_q;
  mix_state_e              state_d;
  logic [K_W-1:0]          k_q;
  logic [K_W-1:0]          k_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic [ADDR_W-1:0]       mem_addr_d;
  logic [SAMPLE_W-1:0]     audio_out_q;
  logic [SAMPLE_W-1:0]     audio_out_d;
  logic                    sample_valid_q;
  logic                    sample_valid_d;
  logic                    overrun_q;
  logic                    overrun_d;

  logic [NUM_CH-1:0]       slot_s;
  logic [NUM_CH-1:0]       active_s;
  logic [NUM_CH-1:0]       done_s;
  logic [ADDR_W-1:0]       ch_addr_s [NUM_CH];
  logic                    other_active_s;
  logic signed [ACC_W-1:0] sample_s;
  logic signed [ACC_W-1:0] contrib_s;
  logic signed [ACC_W-1:0] sum_s;

  // Per-channel control instances
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    audio_channel_ctrl #(
      .ADDR_W (ADDR_W)
    ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger[i]),
      .stop    (stop[i]),
      .loop_en (loop_en[i]),
      .slot    (slot_s[i]),
      .base    (ch_base[i*ADDR_W +: ADDR_W]),
      .len     (ch_len[i*ADDR_W +: ADDR_W]),
      .active  (active_s[i]),
      .rd_addr (ch_addr_s[i]),
      .done    (done_s[i])
    );
  end

  // Decode which channel owns the current ACC slot
  always_comb begin
    slot_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      slot_s[i] = (state_q == ST_ACC) && (k_q == K_W'(i));
    end
  end

  // Signed contribution of the channel in the current slot (ducked if enabled)
  always_comb begin
    other_active_s = 1'b0;
    for (int i = 1; i < NUM_CH; i++) begin
      other_active_s = other_active_s | active_s[i];
    end
    sample_s = $signed({{(ACC_W-SAMPLE_W){1'b0}}, mem_dout}) - MID_ACC;
    if (active_s[k_q]) begin
`ifdef AUDIO_DUCK_EN
      if ((k_q == {K_W{1'b0}}) && other_active_s) begin
        contrib_s = sample_s >>> 1;
      end else begin
        contrib_s = sample_s;
      end
`else
      contrib_s = sample_s;
`endif
    end else begin
      contrib_s = {ACC_W{1'b0}};
    end
  end

  // Mix sequencer next-state, accumulator and output staging
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    acc_d          = acc_q;
    mem_addr_d     = mem_addr_q;
    audio_out_d    = audio_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;
    sum_s          = acc_q + MID_ACC;
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_ADDR;
          k_d     = {K_W{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        mem_addr_d = ch_addr_s[k_q];
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d = acc_q + contrib_s;
        if (k_q == K_W'(NUM_CH - 1)) begin
          state_d = ST_OUT;
        end else begin
          k_d     = k_q + {{(K_W-1){1'b0}}, 1'b1};
          state_d = ST_ADDR;
        end
      end
      ST_OUT: begin
        if (sum_s[ACC_W-1]) begin
          audio_out_d = {SAMPLE_W{1'b0}};
        end else if (sum_s > MAX_ACC) begin
          audio_out_d = {SAMPLE_W{1'b1}};
        end else begin
          audio_out_d = sum_s[SAMPLE_W-1:0];
        end
        sample_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      k_q            <= {K_W{1'b0}};
      acc_q          <= {ACC_W{1'b0}};
      mem_addr_q     <= {ADDR_W{1'b0}};
      audio_out_q    <= MID_OUT;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      mem_addr_q     <= mem_addr_d;
      audio_out_q    <= audio_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign audio_out    = audio_out_q;
  assign sample_valid = sample_valid_q;
  assign active       = active_s;
  assign done         = done_s;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_sfx_mixer.sv
// Directed self-checking bench for audio_sfx_mixer (NUM_CH=4, ADDR_W=16,
// SAMPLE_W=8). Sample memory is modelled as a 1-clk registered read.
module tb_audio_sfx_mixer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [3:0]  trigger;
  logic [3:0]  stop;
  logic [3:0]  loop_en;
  logic [63:0] ch_base;
  logic [63:0] ch_len;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  audio_out;
  logic        sample_valid;
  logic [3:0]  active;
  logic [3:0]  done;
  logic        overrun;

  logic        mem_mode;
  logic [7:0]  mem_const;

  int checks;
  int fails;

  audio_sfx_mixer #(
    .NUM_CH   (4),
    .ADDR_W   (16),
    .SAMPLE_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .trigger      (trigger),
    .stop         (stop),
    .loop_en      (loop_en),
    .ch_base      (ch_base),
    .ch_len       (ch_len),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .audio_out    (audio_out),
    .sample_valid (sample_valid),
    .active       (active),
    .done         (done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory: data = addr[7:0]+128, or a constant, one clock after addr
  always @(posedge clk) begin
    if (mem_mode) mem_dout <= mem_const;
    else          mem_dout <= mem_addr[7:0] + 8'd128;
  end

  task automatic pulse_trigger(input logic [3:0] mask);
    @(negedge clk); trigger = mask;
    @(negedge clk); trigger = 4'b0000;
  endtask

  task automatic pulse_stop(input logic [3:0] mask);
    @(negedge clk); stop = mask;
    @(negedge clk); stop = 4'b0000;
  endtask

  // One tick, wait (bounded) for sample_valid; reports value, latency, done[1] count
  task automatic run_frame(output logic [7:0] val, output int lat, output int dn);
    val = 8'd0; lat = -1; dn = 0;
    @(negedge clk); tick = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) tick = 1'b0;
      if (done[1]) dn++;
      if (sample_valid) begin
        lat = c - 1;
        val = audio_out;
        break;
      end
    end
    if (lat < 0) begin
      checks++; fails++;
      $display("FAIL frame_timeout: no sample_valid within 40 clks");
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (audio_out !== 8'd128) begin fails++; $display("FAIL reset_audio_out: got %0d want 128", audio_out); end
    checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_sample_valid: got %b want 0", sample_valid); end
    checks++; if (active !== 4'b0000) begin fails++; $display("FAIL reset_active: got %b want 0000", active); end
    checks++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (mem_addr !== 16'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_loop;
    logic [7:0] v;
    int lat;
    int dn;
    logic [7:0] exp_out [6];
    exp_out = '{8'd128, 8'd129, 8'd130, 8'd131, 8'd128, 8'd129};
    ch_base[0 +: 16]  = 16'd0;   ch_len[0 +: 16]  = 16'd4; loop_en[0] = 1'b1;
    ch_base[48 +: 16] = 16'd300;
    pulse_trigger(4'b0001);
    for (int f = 0; f < 6; f++) begin
      run_frame(v, lat, dn);
      checks++; if (v !== exp_out[f]) begin fails++; $display("FAIL loop_out[%0d]: got %0d want %0d", f, v, exp_out[f]); end
      if (f == 0) begin
        checks++; if (lat !== 13) begin fails++; $display("FAIL mix_latency: got %0d want 13", lat); end
        checks++; if (mem_addr !== 16'd300) begin fails++; $display("FAIL mem_addr_hold: got %0d want 300", mem_addr); end
      end
    end
  endtask

  task automatic test_oneshot;
    logic [7:0] v;
    int lat;
    int dn;
    pulse_stop(4'b0001);
    ch_base[16 +: 16] = 16'd100; ch_len[16 +: 16] = 16'd2; loop_en[1] = 1'b0;
    pulse_trigger(4'b0010);
    run_frame(v, lat, dn);
    checks++; if (v !== 8'd228) begin fails++; $display("FAIL oneshot_out1: got %0d want 228", v); end
    checks++; if (dn !== 0) begin fails++; $display("FAIL oneshot_done1: got %0d want 0", dn); end
    checks++; if (active[1] !== 1'b1) begin fails++; $display("FAIL oneshot_active1: got %b want 1", active[1]); end
    run_frame(v, lat, dn);
    checks++; if (v !== 8'd229) begin fails++; $display("FAIL oneshot_out2: got %0d want 229", v); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL oneshot_done2: got %0d want 1", dn); end
    checks++; if (active[1] !== 1'b0) begin fails++; $display("FAIL oneshot_active2: got %b want 0", active[1]); end
    run_frame(v, lat, dn);
    checks++; if (v !== 8'd128) begin fails++; $display("FAIL oneshot_out3: got %0d want 128", v); end
  endtask

  task automatic test_saturate;
    logic [7:0] v;
    int lat;
    int dn;
    ch_len = {4{16'd4}};
    loop_en = 4'b1111;
    mem_mode = 1'b1; mem_const = 8'd255;
    pulse_trigger(4'b1111);
    run_frame(v, lat, dn);
    checks++; if (v !== 8'd255) begin fails++; $display("FAIL sat_high: got %0d want 255", v); end
    mem_const = 8'd0;
    run_frame(v, lat, dn);
    checks++; if (v !== 8'd0) begin fails++; $display("FAIL sat_low: got %0d want 0", v); end
    pulse_stop(4'b1111);
    mem_mode = 1'b0;
    checks++; if (active !== 4'b0000) begin fails++; $display("FAIL stop_all: got %b want 0000", active); end
  endtask

  task automatic test_trig_stop;
    ch_len[48 +: 16] = 16'd0;
    @(negedge clk); trigger = 4'b0100; stop = 4'b0100;
    @(negedge clk); trigger = 4'b0000; stop = 4'b0000;
    checks++; if (active[2] !== 1'b0) begin fails++; $display("FAIL stop_wins: got %b want 0", active[2]); end
    pulse_trigger(4'b0100);
    checks++; if (active[2] !== 1'b1) begin fails++; $display("FAIL trig_alone: got %b want 1", active[2]); end
    pulse_stop(4'b0100);
    pulse_trigger(4'b1000);
    checks++; if (active !== 4'b0000) begin fails++; $display("FAIL len0_ignored: got %b want 0000", active); end
  endtask

  task automatic test_overrun_reset;
    int sv;
    sv = 0;
    @(negedge clk); tick = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 || c == 6) tick = 1'b0;
      if (c == 5) tick = 1'b1;
      if (sample_valid) sv++;
    end
    checks++; if (sv !== 1) begin fails++; $display("FAIL overrun_sv_count: got %0d want 1", sv); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    sv = 0;
    @(negedge clk); tick = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin tick = 1'b0; reset = 1'b1; end
      if (c == 2) reset = 1'b0;
      if (sample_valid) sv++;
    end
    checks++; if (sv !== 0) begin fails++; $display("FAIL abort_sv_count: got %0d want 0", sv); end
    checks++; if (audio_out !== 8'd128) begin fails++; $display("FAIL abort_audio_out: got %0d want 128", audio_out); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL abort_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_duck;
    logic [7:0] v;
    int lat;
    int dn;
    logic [7:0] want;
`ifdef AUDIO_DUCK_EN
    want = 8'd160;
`else
    want = 8'd192;
`endif
    ch_base[0 +: 16]  = 16'd64; ch_len[0 +: 16]  = 16'd1;
    ch_base[16 +: 16] = 16'd0;  ch_len[16 +: 16] = 16'd1;
    loop_en = 4'b0011;
    pulse_trigger(4'b0011);
    run_frame(v, lat, dn);
    checks++; if (v !== want) begin fails++; $display("FAIL duck_mix: got %0d want %0d", v, want); end
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b1; tick = 1'b0;
    trigger = 4'b0000; stop = 4'b0000; loop_en = 4'b0000;
    ch_base = 64'd0; ch_len = 64'd0;
    mem_mode = 1'b0; mem_const = 8'd0;
    test_reset();
    test_loop();
    test_oneshot();
    test_saturate();
    test_trig_stop();
    test_overrun_reset();
    test_duck();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
